// File: rtl/jts16b_busarb.sv
// Bus arbiter: takes the System 16B 68000 bus via BRn/BGn/BGACKn and runs one access
// for a secondary master. Optional JTS16B_BUSARB_BURST_EN keeps the bus for up to 4 accesses.
module jts16b_busarb #(
  parameter int TOUT = 255,
  parameter int AW   = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_cen,
  input  logic          req,
  input  logic          req_wr,
  input  logic [AW:1]   req_addr,
  input  logic [1:0]    req_dsn,
  input  logic [15:0]   req_din,
  output logic [15:0]   req_dout,
  output logic          done,
  output logic          err,
  output logic          cpu_brn,
  input  logic          cpu_bgn,
  input  logic          cpu_asn,
  output logic          cpu_bgackn,
  output logic [AW:1]   bm_addr,
  output logic [15:0]   bm_dout,
  output logic          bm_asn,
  output logic [1:0]    bm_dswn,
  input  logic [15:0]   bm_din,
  input  logic          mem_ok
);

  localparam int CW = $clog2(TOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAITAS  = 3'd2,
    S_OWN     = 3'd3,
    S_ACCESS  = 3'd4,
    S_RELEASE = 3'd5
  } state_t;

  state_t         r_st;
  logic           r_wr;
  logic [1:0]     r_dsn;
  logic [AW:1]    r_addr;
  logic [15:0]    r_din;
  logic [CW-1:0]  r_cnt;
`ifdef JTS16B_BUSARB_BURST_EN
  logic [2:0]     r_nacc;
`endif

  logic           w_tout;
  logic           w_cnt_sat;

  // The counter holds the number of ACCESS clocks already elapsed, so the abort
  // lands on the TOUT-th clock in ACCESS.
  assign w_tout    = (r_cnt == CW'(TOUT - 1));
  assign w_cnt_sat = (r_cnt == {CW{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st       <= S_IDLE;
      r_wr       <= 1'b0;
      r_dsn      <= 2'b11;
      r_addr     <= '0;
      r_din      <= 16'h0000;
      r_cnt      <= '0;
      cpu_brn    <= 1'b1;
      cpu_bgackn <= 1'b1;
      bm_asn     <= 1'b1;
      bm_dswn    <= 2'b11;
      bm_addr    <= '0;
      bm_dout    <= 16'h0000;
      req_dout   <= 16'h0000;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef JTS16B_BUSARB_BURST_EN
      r_nacc     <= 3'd0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (r_st)
        S_IDLE: begin
          if (req) begin
            r_wr    <= req_wr;
            r_dsn   <= req_dsn;
            r_addr  <= req_addr;
            r_din   <= req_din;
            cpu_brn <= 1'b0;
            r_st    <= S_REQ;
          end
        end
        S_REQ: begin
          if (cpu_cen && !cpu_bgn) r_st <= S_WAITAS;
        end
        // Only take the bus once the CPU has finished its current bus cycle.
        S_WAITAS: begin
          if (cpu_cen && cpu_asn) begin
            cpu_bgackn <= 1'b0;
            cpu_brn    <= 1'b1;
            r_st       <= S_OWN;
`ifdef JTS16B_BUSARB_BURST_EN
            r_nacc     <= 3'd0;
`endif
          end
        end
        S_OWN: begin
          if (cpu_cen) begin
            bm_addr <= r_addr;
            bm_dout <= r_din;
            bm_asn  <= 1'b0;
            bm_dswn <= r_wr ? r_dsn : 2'b11;
            r_cnt   <= '0;
            r_st    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!w_cnt_sat) r_cnt <= r_cnt + 1'b1;
          // mem_ok takes priority over a coincident timeout.
          if (mem_ok || w_tout) begin
            done    <= 1'b1;
            err     <= !mem_ok;
            bm_asn  <= 1'b1;
            bm_dswn <= 2'b11;
            r_st    <= S_RELEASE;
            if (!r_wr) req_dout <= mem_ok ? bm_din : 16'hFFFF;
`ifdef JTS16B_BUSARB_BURST_EN
            r_nacc  <= r_nacc + 3'd1;
`endif
          end
        end
        S_RELEASE: begin
          if (cpu_cen) begin
`ifdef JTS16B_BUSARB_BURST_EN
            if (req && (r_nacc != 3'd4)) begin
              r_wr   <= req_wr;
              r_dsn  <= req_dsn;
              r_addr <= req_addr;
              r_din  <= req_din;
              r_st   <= S_OWN;
            end else begin
              cpu_bgackn <= 1'b1;
              r_st       <= S_IDLE;
            end
`else
            cpu_bgackn <= 1'b1;
            r_st       <= S_IDLE;
`endif
          end
        end
        default: r_st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jts16b_busarb.sv
// Self-checking bench for jts16b_busarb: directed and random transactions checked
// against a transaction-level model of ownership, data and timeout rules.
module tb_jts16b_busarb;

  localparam int TOUT = 16;
  localparam int AW   = 23;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_cen;
  logic          req;
  logic          req_wr;
  logic [AW:1]   req_addr;
  logic [1:0]    req_dsn;
  logic [15:0]   req_din;
  logic [15:0]   req_dout;
  logic          done;
  logic          err;
  logic          cpu_brn;
  logic          cpu_bgn;
  logic          cpu_asn;
  logic          cpu_bgackn;
  logic [AW:1]   bm_addr;
  logic [15:0]   bm_dout;
  logic          bm_asn;
  logic [1:0]    bm_dswn;
  logic [15:0]   bm_din;
  logic          mem_ok;

  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [15:0]   exp_dout;

  jts16b_busarb #(.TOUT(TOUT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_dsn(req_dsn),
    .req_din(req_din), .req_dout(req_dout), .done(done), .err(err),
    .cpu_brn(cpu_brn), .cpu_bgn(cpu_bgn), .cpu_asn(cpu_asn), .cpu_bgackn(cpu_bgackn),
    .bm_addr(bm_addr), .bm_dout(bm_dout), .bm_asn(bm_asn), .bm_dswn(bm_dswn),
    .bm_din(bm_din), .mem_ok(mem_ok)
  );

  initial forever #5 clk = ~clk;

  // Outputs are sampled on the falling edge; cpu_cen is high on every second clk.
  task automatic tick();
    @(negedge clk);
    cyc++;
    cpu_cen = (cyc % 2 == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_brn"},   {31'd0, cpu_brn},    32'd1);
    chk({tag, "_bgack"}, {31'd0, cpu_bgackn}, 32'd1);
    chk({tag, "_asn"},   {31'd0, bm_asn},     32'd1);
    chk({tag, "_dswn"},  {30'd0, bm_dswn},    32'd3);
    chk({tag, "_addr"},  {9'd0, bm_addr},     32'd0);
    chk({tag, "_bdout"}, {16'd0, bm_dout},    32'd0);
    chk({tag, "_rdout"}, {16'd0, req_dout},   32'd0);
    chk({tag, "_done"},  {30'd0, done, err},  32'd0);
  endtask

  // One requester access. ok_dly: ACCESS clocks before mem_ok rises (large = never).
  // rst_at > 0 asserts reset on that ACCESS clock instead of completing.
  task automatic run_txn(input logic wr, input logic [AW:1] addr, input logic [1:0] dsn,
                         input logic [15:0] din, input logic [15:0] rdat,
                         input int gnt_cens, input int busy_cens, input int ok_dly,
                         input int rst_at);
    int          j;
    int          n;
    bit          got;
    bit          quiet;
    bit          stable;
    int          e_done;
    bit          e_err;
    logic [15:0] e_dout;
    logic [1:0]  e_dswn;

    e_done = (ok_dly + 1 < TOUT) ? ok_dly + 1 : TOUT;
    e_err  = (ok_dly + 1 > TOUT);
    e_dout = wr ? exp_dout : (e_err ? 16'hFFFF : rdat);
    e_dswn = wr ? dsn : 2'b11;

    req_wr = wr; req_addr = addr; req_dsn = dsn; req_din = din;
    bm_din = rdat; mem_ok = 1'b0; cpu_bgn = 1'b1;
    cpu_asn = (busy_cens == 0);
    req = 1'b1;
    tick();
    chk("brn_low", {31'd0, cpu_brn}, 32'd0);
    chk("bgack_before_grant", {31'd0, cpu_bgackn}, 32'd1);
    req = 1'($urandom_range(0, 1));

    quiet = 1'b1;
    for (int k = 0; k < gnt_cens * 2; k++) begin
      tick();
      if (cpu_brn !== 1'b0 || cpu_bgackn !== 1'b1) quiet = 1'b0;
    end
    chk("hold_without_grant", {31'd0, quiet}, 32'd1);
    cpu_bgn = 1'b0;

    quiet = 1'b1;
    for (int k = 0; k < busy_cens * 2; k++) begin
      tick();
      if (cpu_bgackn !== 1'b1 || bm_asn !== 1'b1) quiet = 1'b0;
    end
    chk("no_own_while_cpu_as", {31'd0, quiet}, 32'd1);
    cpu_asn = 1'b1;

    n = 0;
    while (bm_asn !== 1'b0 && n < 12) begin
      tick();
      n++;
      if (cpu_bgackn === 1'b0) cpu_bgn = 1'b1;
    end
    chk("own_reached", {31'd0, bm_asn}, 32'd0);
    if (bm_asn !== 1'b0) return;
    cpu_bgn = 1'b1;
    chk("own_bgack", {31'd0, cpu_bgackn}, 32'd0);
    chk("own_brn", {31'd0, cpu_brn}, 32'd1);
    chk("own_addr", {9'd0, bm_addr}, {9'd0, addr});
    chk("own_dout", {16'd0, bm_dout}, {16'd0, din});
    chk("own_dswn", {30'd0, bm_dswn}, {30'd0, e_dswn});

    got = 1'b0; stable = 1'b1; j = 0;
    while (!got && j < TOUT + 4) begin
      tick();
      j++;
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (bm_asn !== 1'b0 || bm_addr !== addr || bm_dout !== din || bm_dswn !== e_dswn)
          stable = 1'b0;
        mem_ok = (j >= ok_dly);
        if (j == rst_at) begin
          rst = 1'b1;
          #1;
          chk_reset_vals("rst_mid");
          rst = 1'b0; req = 1'b0; mem_ok = 1'b0; cpu_bgn = 1'b1;
          exp_dout = 16'h0000;
          tick();
          return;
        end
      end
    end
    chk("bus_stable", {31'd0, stable}, 32'd1);
    chk("done_clk", j, e_done);
    chk("err", {31'd0, err}, {31'd0, e_err});
    chk("req_dout", {16'd0, req_dout}, {16'd0, e_dout});
    chk("strobes_off", {29'd0, bm_asn, bm_dswn}, 32'd7);
    exp_dout = e_dout;

    mem_ok = 1'b0; req = 1'b0;
    tick();
    chk("done_pulse", {30'd0, done, err}, 32'd0);
    n = 1;
    while (cpu_bgackn !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    chk("bgack_release", {31'd0, cpu_bgackn}, 32'd1);
    chk("release_clks_le2", {31'd0, (n <= 2)}, 32'd1);
    tick();
    chk("idle_brn", {30'd0, cpu_brn, bm_asn}, 32'd3);
  endtask

  initial begin
    rst = 1'b1; cpu_cen = 1'b0; req = 1'b0; req_wr = 1'b0; req_addr = '0;
    req_dsn = 2'b11; req_din = 16'h0000; cpu_bgn = 1'b1; cpu_asn = 1'b1;
    bm_din = 16'h0000; mem_ok = 1'b0; exp_dout = 16'h0000;
    tick(); tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(); tick();

    run_txn(1'b0, 23'h3F000, 2'b00, 16'h1234, 16'hA55A, 1, 0, 5, 0);
    run_txn(1'b0, 23'h00123, 2'b00, 16'h0000, 16'h5AA5, 0, 6, 2, 0);
    run_txn(1'b1, 23'h7FFFF, 2'b10, 16'h0012, 16'hDEAD, 2, 1, 3, 0);
    run_txn(1'b0, 23'h40000, 2'b00, 16'h0000, 16'hBEEF, 0, 0, 1000, 0);
    run_txn(1'b1, 23'h40002, 2'b01, 16'h3400, 16'h0000, 0, 0, 1000, 0);
    run_txn(1'b0, 23'h00002, 2'b00, 16'h0000, 16'hC0DE, 1, 0, TOUT - 1, 0);
    run_txn(1'b0, 23'h00004, 2'b00, 16'h0000, 16'h1111, 0, 0, TOUT - 2, 0);
    run_txn(1'b0, 23'h00006, 2'b00, 16'h0000, 16'h2222, 0, 2, 10, 3);
    run_txn(1'b0, 23'h00008, 2'b00, 16'h0000, 16'h3333, 0, 0, 1, 0);

    for (int t = 0; t < 20; t++) begin
      run_txn(1'($urandom_range(0, 1)), 23'($urandom), 2'($urandom), 16'($urandom),
              16'($urandom), $urandom_range(0, 3), $urandom_range(0, 4),
              $urandom_range(1, TOUT + 3), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jts16b_busarb.md
Name: jts16b_busarb

Overview:
- Bus arbiter between the System 16B 68000 and a secondary bus master (i8751 MCU via mapper DMA path).
- Runs the 68000 BRn/BGn/BGACKn handshake to take bus ownership.
- Performs one byte/word access on the main bus on the requester's behalf, then returns the bus to the CPU.
- Sits between the memory mapper, the CPU wrapper and the bus chip-select decode.

Parameters:
- TOUT, 255: clk cycles allowed in ACCESS for mem_ok before abort.
- AW, 23: address width (bits [AW:1]).

Ports:
- clk  in  1  system clock
- rst  in  1  async reset, active-high
- cpu_cen  in  1  68000 clock enable; all CPU-facing handshake sampling happens only on cpu_cen
- req  in  1  requester access strobe, level; held until done
- req_wr  in  1  1=write, 0=read
- req_addr  in  AW  word address
- req_dsn  in  2  {UDSn,LDSn} byte select, active low
- req_din  in  16  write data
- req_dout  out  16  read data, valid with done
- done  out  1  one-clk pulse, access complete
- err  out  1  one-clk pulse, access aborted on timeout (coincident with done)
- cpu_brn  out  1  bus request to 68000
- cpu_bgn  in  1  bus grant from 68000
- cpu_asn  in  1  68000 address strobe
- cpu_bgackn  out  1  bus grant acknowledge
- bm_addr  out  AW  master address onto bus
- bm_dout  out  16  master write data
- bm_asn  out  1  master address strobe
- bm_dswn  out  2  master write strobes, active low
- bm_din  in  16  bus read data
- mem_ok  in  1  target acknowledge

Behaviour:
- Reset values:
  - cpu_brn=1, cpu_bgackn=1, bm_asn=1, bm_dswn=2'b11
  - bm_addr=0, bm_dout=0, req_dout=0, done=0, err=0
  - state=IDLE
- FSM states: IDLE, REQ, WAITAS, OWN, ACCESS, RELEASE.
- IDLE: on req=1 (any clk), latch req_addr/req_din/req_dsn/req_wr; cpu_brn<=0; go to REQ.
- REQ: on cpu_cen with cpu_bgn=0, go to WAITAS.
- WAITAS: on cpu_cen with cpu_asn=1 (previous CPU cycle finished): cpu_bgackn<=0, cpu_brn<=1; go to OWN.
- OWN: on the next cpu_cen: bm_addr, bm_dout driven; bm_asn<=0; bm_dswn<=req_wr ? req_dsn : 2'b11; clear timeout counter; go to ACCESS.
- ACCESS:
  - Counter increments every clk.
  - On mem_ok=1: capture req_dout<=bm_din on reads (unchanged on writes); done<=1; bm_asn<=1; bm_dswn<=2'b11; go to RELEASE.
  - If counter==TOUT before mem_ok: done<=1, err<=1, req_dout<=16'hFFFF on reads; deassert strobes; go to RELEASE.
  - mem_ok and timeout in the same clk: mem_ok wins, no err.
- RELEASE:
  - On cpu_cen: cpu_bgackn<=1; go to IDLE.
  - Requester must drop req after done. A req still high in IDLE after RELEASE is treated as a new request.
- Latency: minimum from req to done is 3 cpu_cen edges plus mem_ok delay. The bus is never owned while cpu_asn=0.
- Bus address and data are held constant from OWN through the done clk.
- req falling mid-transaction is ignored; the access always completes.
- cpu_bgn rising while in REQ (grant withdrawn): stay in REQ with cpu_brn=0.
- rst mid-transaction forces the reset values immediately. The CPU regains the bus because BGACKn is released.
- Counter saturates and never wraps.

Optional Feature:
- Macro JTS16B_BUSARB_BURST_EN.
- When defined: in RELEASE, if req=1 on that cpu_cen, skip bus release and go directly to OWN with freshly latched request fields. At most 4 consecutive accesses are allowed per tenure; the 4th always releases.
- When undefined: every access releases the bus (one access per tenure).

Test Plan:
- Read, CPU idle: req read addr 0x3F000, mem_ok 5 clk after bm_asn=0, bm_din=16'hA55A -> cpu_brn low in 1 clk; bgackn low after bgn=0 & asn=1; done pulse with req_dout=A55A; bgackn=1 on next cpu_cen.
- CPU mid-cycle: grant arrives while cpu_asn=0 for 6 cpu_cen -> bgackn stays 1 and bm_asn stays 1 until cpu_asn=1.
- Write, low byte: req_wr=1, req_dsn=2'b10, req_din=16'h0012 -> bm_dswn=2'b10 and bm_dout=0012 throughout ACCESS; no req_dout change.
- Timeout: TOUT=16, mem_ok never asserts -> done and err pulse together 16 clk into ACCESS, req_dout=FFFF, bus released.
- Reset during ACCESS -> all outputs at reset values the same clk; next req proceeds normally.
- BURST_EN: 5 back-to-back reads -> 4 done pulses within one BGACKn low window, then bgackn=1, then a fresh BRn for the 5th.
